// File: rtl/lif_array_if.sv
// lif_array_if: address-event stream of lif_array (valid/ready handshake) together
// with the sticky overflow flag that qualifies it.
interface lif_array_if #(
   parameter int N_CH = 4
);
   localparam int AW = $clog2(N_CH);

   logic          ev_valid;
   logic          ev_ready;
   logic [AW-1:0] ev_addr;
   logic          ev_overflow;

   modport master (
      output ev_valid,
      output ev_addr,
      output ev_overflow,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_addr,
      input  ev_overflow,
      output ev_ready
   );
endinterface

// File: rtl/lif_array.sv
// lif_array: N_CH leaky integrate-and-fire neurons sharing one config register file,
// advanced by a tick strobe, with spikes reported as a round-robin AER stream.
module lif_array #(
   parameter int N_CH        = 4,
   parameter int W           = 8,
   parameter int RW          = 4,
   parameter int THRESH_INIT = 200,
   parameter int LEAK_INIT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [N_CH*W-1:0] current,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [W-1:0]      cfg_wdata,
   output logic [N_CH*W-1:0] state,
   output logic [N_CH-1:0]   spike,
   lif_array_if.master       ev
);

   localparam int AW = $clog2(N_CH);
   localparam int LW = $clog2(W + 1);

   typedef enum logic [1:0] {
      CFG_THRESH = 2'd0,
      CFG_LEAK   = 2'd1,
      CFG_REFR   = 2'd2,
      CFG_CTRL   = 2'd3
   } cfg_sel_e;

   // Shared configuration
   logic [W-1:0]  thresh_q;
   logic [LW-1:0] leak_q;
   logic [RW-1:0] refr_per_q;
   logic          sub_mode_q;
   logic          enable_q;

   // Per-channel neuron state
   logic [N_CH-1:0][W-1:0]  mem_q, mem_d;
   logic [N_CH-1:0][RW-1:0] refr_q, refr_d;
   logic [N_CH-1:0]         spike_q, fire_d;
   logic [N_CH-1:0][W-1:0]  cur;
   logic [N_CH-1:0][W-1:0]  leaked, sum_sat;
   logic [N_CH-1:0][W:0]    sum_wide;
   logic                    step;

   // Event arbitration
   logic [N_CH-1:0] pending_q, pending_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   ev_sel, sel_hi, sel_lo;
   logic            hit_hi;
   logic            grant;
   logic            ovf_q, ovf_set, ovf_clr;

   assign cur = current;

   // NOTE: sequential state always uses non-blocking (<=) so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thresh_q   <= W'(THRESH_INIT);
         leak_q     <= LW'(LEAK_INIT);
         refr_per_q <= '0;
         sub_mode_q <= 1'b0;
         enable_q   <= 1'b1;
      end else if (cfg_we) begin
         case (cfg_sel_e'(cfg_addr))
            CFG_THRESH: thresh_q   <= cfg_wdata;
            CFG_LEAK:   leak_q     <= cfg_wdata[LW-1:0];
            CFG_REFR:   refr_per_q <= cfg_wdata[RW-1:0];
            CFG_CTRL: begin
               sub_mode_q <= cfg_wdata[0];
               enable_q   <= cfg_wdata[1];
            end
            default: ;
         endcase
      end
   end

   assign step = tick && enable_q;

   // NOTE: every signal written here gets its default before any branch,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         leaked[c]   = (leak_q >= LW'(W)) ? '0 : (mem_q[c] >> leak_q);
         sum_wide[c] = {1'b0, leaked[c]} + {1'b0, cur[c]};
         sum_sat[c]  = sum_wide[c][W] ? '1 : sum_wide[c][W-1:0];
         mem_d[c]    = mem_q[c];
         refr_d[c]   = refr_q[c];
         fire_d[c]   = 1'b0;
         if (step) begin
            if (refr_q[c] != '0) begin
               // Refractory: keep leaking but ignore input and never fire
               mem_d[c]  = leaked[c];
               refr_d[c] = refr_q[c] - RW'(1);
            end else if (sum_sat[c] >= thresh_q) begin
               fire_d[c] = 1'b1;
               mem_d[c]  = sub_mode_q ? (sum_sat[c] - thresh_q) : '0;
               refr_d[c] = refr_per_q;
            end else begin
               mem_d[c] = sum_sat[c];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '0;
         refr_q  <= '0;
         spike_q <= '0;
      end else begin
         mem_q   <= mem_d;
         refr_q  <= refr_d;
         spike_q <= fire_d;
      end
   end

   // Round-robin pick: lowest pending channel at or above the pointer,
   // otherwise the lowest pending channel overall (the wrapped case).
   always_comb begin
      hit_hi = 1'b0;
      sel_hi = '0;
      sel_lo = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (pending_q[c]) begin
            sel_lo = AW'(c);
            if (c >= int'(ptr_q)) begin
               hit_hi = 1'b1;
               sel_hi = AW'(c);
            end
         end
      end
      ev_sel = hit_hi ? sel_hi : sel_lo;
   end

   assign grant   = (|pending_q) && ev.ev_ready;
   assign ovf_clr = cfg_we && (cfg_sel_e'(cfg_addr) == CFG_CTRL) && cfg_wdata[7];

   always_comb begin
      pending_d = pending_q;
      ptr_d     = ptr_q;
      ovf_set   = 1'b0;
      if (grant) begin
         pending_d[ev_sel] = 1'b0;
         ptr_d = (ev_sel == AW'(N_CH - 1)) ? '0 : ev_sel + AW'(1);
      end
      // A spike on the granted channel re-arms it; one on any other pending
      // channel is folded into the existing event and flagged.
      for (int c = 0; c < N_CH; c++) begin
         if (fire_d[c]) begin
            if (pending_d[c]) begin
               ovf_set = 1'b1;
            end
            pending_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         ptr_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign state          = mem_q;
   assign spike          = spike_q;
   assign ev.ev_valid    = |pending_q;
   assign ev.ev_addr     = ev_sel;
   assign ev.ev_overflow = ovf_q;

   a_addr_pending: assert property (@(posedge clk) disable iff (rst)
      ev.ev_valid |-> pending_q[ev_sel]);

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a behavioural model.
module tb_lif_array;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int RW   = 4;
   localparam int AW   = $clog2(N);
   localparam int MAXV = (1 << W) - 1;
   localparam int LMOD = 1 << $clog2(W + 1);
   localparam int RMOD = 1 << RW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           tick = 1'b0;
   logic [N*W-1:0] current = '0;
   logic           cfg_we = 1'b0;
   logic [1:0]     cfg_addr = '0;
   logic [W-1:0]   cfg_wdata = '0;
   logic [N*W-1:0] state;
   logic [N-1:0]   spike;

   lif_array_if #(.N_CH(N)) ev_if ();

   lif_array #(
      .N_CH(N), .W(W), .RW(RW), .THRESH_INIT(200), .LEAK_INIT(1)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .current(current),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .state(state), .spike(spike), .ev(ev_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model
   int m_mem [N];
   int m_refr[N];
   int m_th, m_leak, m_rp;
   bit m_sub, m_en;
   bit m_pend [N];
   int m_ptr;
   bit m_ovf;
   bit m_spike[N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_mem[c] = 0; m_refr[c] = 0; m_pend[c] = 0; m_spike[c] = 0;
      end
      m_th = 200; m_leak = 1; m_rp = 0; m_sub = 0; m_en = 1;
      m_ptr = 0; m_ovf = 0;
   endtask

   // Advances the model by one clock using the inputs currently applied.
   task automatic model_step();
      int g;
      int lk;
      int sum;
      bit set_ovf;
      bit fire[N];
      g = -1;
      if (ev_if.ev_ready) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (g < 0 && m_pend[k]) g = k;
         end
      end
      for (int c = 0; c < N; c++) begin
         fire[c] = 0;
         if (tick && m_en) begin
            lk = m_mem[c] / (1 << m_leak);
            if (m_leak >= W) lk = 0;
            if (m_refr[c] > 0) begin
               m_mem[c] = lk;
               m_refr[c] = m_refr[c] - 1;
            end else begin
               sum = lk + int'(current[c*W +: W]);
               if (sum > MAXV) sum = MAXV;
               if (sum >= m_th) begin
                  fire[c] = 1;
                  m_mem[c] = m_sub ? sum - m_th : 0;
                  m_refr[c] = m_rp;
               end else begin
                  m_mem[c] = sum;
               end
            end
         end
      end
      if (g >= 0) begin
         m_pend[g] = 0;
         m_ptr = (g + 1) % N;
      end
      set_ovf = 0;
      for (int c = 0; c < N; c++) begin
         if (fire[c]) begin
            if (m_pend[c]) set_ovf = 1;
            m_pend[c] = 1;
         end
      end
      if (set_ovf) m_ovf = 1;
      else if (cfg_we && cfg_addr == 2'd3 && cfg_wdata[7]) m_ovf = 0;
      if (cfg_we) begin
         case (cfg_addr)
            2'd0: m_th = int'(cfg_wdata);
            2'd1: m_leak = int'(cfg_wdata) % LMOD;
            2'd2: m_rp = int'(cfg_wdata) % RMOD;
            default: begin
               m_sub = cfg_wdata[0];
               m_en  = cfg_wdata[1];
            end
         endcase
      end
      m_spike = fire;
   endtask

   task automatic compare_outputs();
      logic [N*W-1:0] exp_state;
      logic [N-1:0]   exp_spike;
      bit             exp_valid;
      int             exp_addr;
      exp_valid = 0;
      exp_addr  = 0;
      for (int c = 0; c < N; c++) begin
         exp_state[c*W +: W] = W'(m_mem[c]);
         exp_spike[c] = m_spike[c];
      end
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_ptr + i) % N;
         if (!exp_valid && m_pend[k]) begin
            exp_valid = 1;
            exp_addr = k;
         end
      end
      check("state", 32'(state), 32'(exp_state));
      check("spike", 32'(spike), 32'(exp_spike));
      check("ev_valid", 32'(ev_if.ev_valid), 32'(exp_valid));
      if (exp_valid) check("ev_addr", 32'(ev_if.ev_addr), 32'(exp_addr));
      check("ev_overflow", 32'(ev_if.ev_overflow), 32'(m_ovf));
   endtask

   // Called just after a falling edge: model consumes the inputs, DUT clocks, compare.
   task automatic clk_cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic do_reset();
      tick = 1'b0;
      cfg_we = 1'b0;
      #1 rst = 1'b1;
      #1 model_reset();
      compare_outputs();
      #1 rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [W-1:0] d);
      tick = 1'b0;
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_wdata = d;
      clk_cycle();
      cfg_we = 1'b0;
   endtask

   task automatic tick_check(input string nm, input int ch, input int exp_mem, input bit exp_spk);
      tick = 1'b1;
      clk_cycle();
      check({nm, "_state"}, 32'(state[ch*W +: W]), 32'(exp_mem));
      check({nm, "_spike"}, 32'(spike[ch]), 32'(exp_spk));
      check({nm, "_model"}, 32'(m_mem[ch]), 32'(exp_mem));
   endtask

   int seq_a[9] = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
   int seq_b[7] = '{101, 151, 176, 189, 195, 198, 0};
   int seq_c[3] = '{100, 200, 0};
   int seq_d[5] = '{100, 50, 50, 50, 0};
   bit spk_d[5] = '{0, 1, 0, 0, 1};

   initial begin
      ev_if.ev_ready = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();

      // Default config, sub-threshold drive settles at 199
      current = {8'd0, 8'd0, 8'd0, 8'd100};
      for (int i = 0; i < 9; i++) tick_check("leak_100", 0, seq_a[i], 1'b0);

      do_reset();
      current = {8'd0, 8'd0, 8'd0, 8'd101};
      for (int i = 0; i < 7; i++) tick_check("leak_101", 0, seq_b[i], i == 6);

      // Saturation must fire instead of wrapping
      do_reset();
      cfg_write(2'd0, 8'd255);
      cfg_write(2'd1, 8'd0);
      current = {8'd0, 8'd0, 8'd100, 8'd0};
      for (int i = 0; i < 3; i++) tick_check("sat", 1, seq_c[i], i == 2);

      // Subtract mode with refractory period 2
      do_reset();
      cfg_write(2'd0, 8'd150);
      cfg_write(2'd1, 8'd0);
      cfg_write(2'd2, 8'd2);
      cfg_write(2'd3, 8'h03);
      current = {8'd0, 8'd100, 8'd0, 8'd0};
      for (int i = 0; i < 5; i++) tick_check("sub_refr", 2, seq_d[i], spk_d[i]);

      // AER burst with back-pressure
      do_reset();
      cfg_write(2'd0, 8'd10);
      current = {8'd50, 8'd50, 8'd50, 8'd50};
      ev_if.ev_ready = 1'b0;
      tick = 1'b1;
      clk_cycle();
      tick = 1'b0;
      check("burst_spike", 32'(spike), 32'hF);
      for (int i = 0; i < 3; i++) begin
         clk_cycle();
         check("burst_hold_valid", 32'(ev_if.ev_valid), 32'd1);
         check("burst_hold_addr", 32'(ev_if.ev_addr), 32'd0);
      end
      ev_if.ev_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         check("burst_addr", 32'(ev_if.ev_addr), 32'(k));
         clk_cycle();
      end
      check("burst_drained", 32'(ev_if.ev_valid), 32'd0);
      check("burst_ptr_model", 32'(m_ptr), 32'd0);
      ev_if.ev_ready = 1'b0;
      tick = 1'b1;
      clk_cycle();
      tick = 1'b0;
      check("burst_ptr_wrap", 32'(ev_if.ev_addr), 32'd0);
      ev_if.ev_ready = 1'b1;
      for (int k = 0; k < N; k++) clk_cycle();

      // Overflow on a merged event, then write-1-to-clear
      do_reset();
      cfg_write(2'd0, 8'd10);
      current = {8'd50, 8'd0, 8'd0, 8'd0};
      ev_if.ev_ready = 1'b0;
      tick = 1'b1;
      clk_cycle();
      clk_cycle();
      tick = 1'b0;
      check("ovf_set", 32'(ev_if.ev_overflow), 32'd1);
      check("ovf_addr", 32'(ev_if.ev_addr), 32'd3);
      ev_if.ev_ready = 1'b1;
      clk_cycle();
      check("ovf_single_event", 32'(ev_if.ev_valid), 32'd0);
      cfg_write(2'd3, 8'h82);
      check("ovf_clear", 32'(ev_if.ev_overflow), 32'd0);
      tick_check("ovf_ctrl_kept", 3, 0, 1'b1);

      // Asynchronous reset while events pend and membranes are nonzero
      do_reset();
      cfg_write(2'd0, 8'd60);
      current = {8'd30, 8'd30, 8'd30, 8'd100};
      ev_if.ev_ready = 1'b0;
      tick = 1'b1;
      clk_cycle();
      tick = 1'b0;
      check("pre_rst_state", 32'(state[W +: W]), 32'd30);
      check("pre_rst_valid", 32'(ev_if.ev_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_spike", 32'(spike), 32'd0);
      check("arst_valid", 32'(ev_if.ev_valid), 32'd0);
      check("arst_ovf", 32'(ev_if.ev_overflow), 32'd0);
      model_reset();
      #1 rst = 1'b0;
      ev_if.ev_ready = 1'b1;
      current = {8'd0, 8'd0, 8'd0, 8'd100};
      tick_check("arst_defaults", 0, 100, 1'b0);
      tick_check("arst_defaults", 0, 150, 1'b0);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         tick = ($urandom_range(0, 2) != 0);
         for (int c = 0; c < N; c++) current[c*W +: W] = W'($urandom_range(0, 120));
         ev_if.ev_ready = ($urandom_range(0, 3) != 0);
         cfg_we = ($urandom_range(0, 15) == 0);
         cfg_addr = 2'($urandom_range(0, 3));
         cfg_wdata = W'($urandom);
         if (cfg_addr == 2'd0) cfg_wdata = W'($urandom_range(60, 255));
         if (cfg_addr == 2'd3 && $urandom_range(0, 4) != 0) cfg_wdata[1] = 1'b1;
         clk_cycle();
      end
      cfg_we = 1'b0;
      tick = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lif_array.md
# lif_array

Parametrised array of N_CH leaky integrate-and-fire neurons sharing one configuration register file, with programmable threshold, leak shift, refractory period and reset mode. Membranes advance only on a `tick` strobe, so the time step is decoupled from `clk`. Spikes appear as a per-channel pulse vector and as a round-robin address-event (AER) stream with a valid/ready handshake. The block is the multi-channel successor to the single-neuron `lif` core and is intended to sit directly behind the top-level pin wrapper.

## Interface
- `N_CH`, 4: neuron channel count (≥2); `AW = $clog2(N_CH)`.
- `W`, 8: membrane, current and threshold width.
- `RW`, 4: refractory counter width (≤ W).
- `THRESH_INIT`, 200: threshold reset value.
- `LEAK_INIT`, 1: leak shift reset value.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: time-step strobe; one update per high cycle.
- `current` in N_CH*W: unsigned input current; channel c occupies bits [c*W +: W].
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 2: 0 = threshold, 1 = leak shift (low $clog2(W+1) bits), 2 = refractory period (low RW bits), 3 = control.
- `cfg_wdata` in W: write data. Control register: bit0 = reset mode (0 zero, 1 subtract), bit1 = enable, bit7 = write-1-to-clear `ev_overflow` (self-clearing, not stored).
- `state` out N_CH*W: registered membrane values.
- `spike` out N_CH: one-cycle pulse per firing channel.
- `ev_valid` out 1: an event is pending.
- `ev_ready` in 1: consumer accepts the event.
- `ev_addr` out AW: channel of the offered event.
- `ev_overflow` out 1: sticky; set when a spike merges into a still-pending event.

## Operation
- Reset values: `state` = 0, refractory counters = 0, `spike` = 0, pending bits = 0, round-robin pointer = 0, `ev_overflow` = 0. Config resets to threshold = THRESH_INIT, leak = LEAK_INIT, refractory = 0, control = 0b10 (enabled, reset-to-zero).
- Per-channel update, on a `tick` cycle with enable = 1:
  - leaked = state >> leak. Leak 0 means no leak. Leak ≥ W gives 0.
  - If refr ≠ 0: state ← leaked, refr ← refr − 1, input ignored, no spike.
  - Otherwise: sum = leaked + current, computed in W+1 bits and saturated to 2^W−1.
    - If sum ≥ threshold: spike. State ← 0 in zero mode, or sum − threshold in subtract mode. Refr ← refractory period.
    - Otherwise: state ← sum.
- Enable = 0: ticks are ignored. State and refractory counters hold. The event stream still drains.
- A config write on a tick cycle takes effect at the next tick; the current update uses the old values.
- Events:
  - A spike on channel c sets pending[c].
  - `ev_valid` = OR of all pending bits.
  - `ev_addr` = first pending channel at or after the pointer, wrapping modulo N_CH.
  - On `ev_valid && ev_ready`: pending[ev_addr] clears and the pointer ← ev_addr + 1 (mod N_CH).
- Simultaneous events:
  - Spike on the channel being granted in the same cycle: pending stays set (new event), no overflow.
  - Spike on a channel already pending and not granted: event merged, `ev_overflow` ← 1.
  - Overflow clear and overflow set in the same cycle: set wins.

## Timing
- `state` and `spike` update at the edge ending the `tick` cycle. `spike` is high for exactly that one following cycle.
- The pending bit is set at the same edge, so `ev_valid` rises one cycle after `tick`.
- `ev_valid` and `ev_addr` are combinational from registers only. They must not depend on `ev_ready`.
- Throughput: one event per cycle while `ev_ready` = 1.
- `rst` asserted at any time clears all outputs immediately, without waiting for `clk`. This includes mid-burst events.

## Test plan
- Defaults (threshold 200, leak 1), ch0 current 100, tick every cycle → state 100, 150, 175, 187, 193, 196, 198, 199, 199 …, never spikes. With current 101 → 101, 151, 176, 189, 195, 198, then 200 triggers a spike on the 7th tick and state 0.
- Saturation: threshold 255, leak 0, ch1 current 100 → 100, 200, then saturation to 255 triggers a spike on the 3rd tick and state 0. A wrapping implementation would give 44 with no spike; that is a fail.
- Subtract mode with refractory: threshold 150, leak 0, refractory 2, ch2 current 100 → 100; 200 spikes and leaves 50; 50 and 50 during refractory (no spike); 150 spikes, 0 on the 5th tick.
- AER burst: all four channels spike on one tick, `ev_ready` low for 3 cycles then high → `ev_valid` holds with `ev_addr` 0. Then addresses 0, 1, 2, 3 are accepted on consecutive cycles and `ev_valid` falls. The pointer ends at 0.
- Overflow: ch3 spikes on two ticks while `ev_ready` = 0 → a single ch3 event and `ev_overflow` = 1. Writing addr 3 with 0x82 → `ev_overflow` = 0, control unchanged.
- Async reset: pulse `rst` between clock edges while events are pending and state is nonzero → `ev_valid`, `state`, `spike` and `ev_overflow` go to 0 before the next edge. Config returns to defaults.
